pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Program-counter register and next-PC selector for the KGP_RISC fetch stage.
//   Holds the current PC that drives instruction memory and the PC incrementor.
//   Each cycle it loads one of: the incremented PC returned by the incrementor,
//   a branch target, a jump target, or its current value (stall/halt).
//   Buffers one redirect that arrives during a stall, records a link address,
//   and sequences halt/resume.
// PARAMETERS
//   PC_W      8      PC / address width in bits
//   RESET_PC  8'h00  PC value loaded on reset
// PORTS
//   clk            in   1     system clock; all state updates on rising edge
//   rst            in   1     synchronous, active-high reset
//   pc_inc         in   PC_W  incrementor result; must equal pc+1 mod 2^PC_W
//   branch_taken   in   1     conditional branch resolved taken this cycle
//   branch_target  in   PC_W  branch destination
//   jump_en        in   1     unconditional jump this cycle
//   jump_target    in   PC_W  jump destination
//   link_en        in   1     with jump_en: save return address (jal)
//   stall          in   1     hold PC (downstream not ready)
//   halt_req       in   1     halt instruction decoded
//   resume         in   1     leave HALT
//   pc             out  PC_W  current PC, registered
//   flush          out  1     one-cycle pulse: the preceding fetch is wrong-path
//   link_addr      out  PC_W  last saved return address, registered
//   halted         out  1     1 while in HALT, registered
// BEHAVIOUR
//   Reset (rst=1 at an edge, overrides everything, also mid-stall or in HALT):
//     pc=RESET_PC, state=RUN, flush=0, halted=0, link_addr=0, pend_valid=0.
//   States: RUN, HALT. The registers pend_valid/pend_target hold a buffered redirect.
//   redirect = jump_en | branch_taken. Target is jump_target if jump_en, else branch_target.
//   RUN, evaluated in priority order each edge:
//     1 stall=1: pc holds. If redirect and !pend_valid, capture target and set
//       pend_valid=1. If pend_valid is already 1, later redirects are ignored
//       (the oldest one wins).
//     2 stall=0, pend_valid=1: pc<=pend_target, pend_valid<=0, flush<=1.
//       Same-cycle redirect, halt_req, and link_en are ignored.
//     3 stall=0, halt_req=1: state<=HALT, pc holds, halted<=1. A redirect in the
//       same cycle is dropped.
//     4 stall=0, redirect=1: pc<=target, flush<=1. jump_en has priority over
//       branch_taken.
//     5 otherwise: pc<=pc_inc.
//   link: when jump_en & link_en are accepted (case 4 with jump_en, or captured
//     under case 1), link_addr<=pc_inc at that edge.
//   flush is high for exactly the one cycle after an edge that loaded a
//     redirect target; it is 0 otherwise.
//   HALT: pc, link_addr, and pend regs hold. redirect, stall, and halt_req are
//     ignored. When resume=1: state<=RUN, halted<=0, pc<=pc_inc (no flush).
//   Latency: redirect to new pc is 1 cycle. Buffered redirect is applied on the
//     first edge with stall=0.
//   Width: pc_inc is used as-is, so 0xFF wraps to 0x00. No overflow flag.
//     All targets are PC_W bits and are not checked.
// TESTING
//   T1 reset, then 4 free-running cycles -> pc 00,01,02,03,04; flush=0, halted=0.
//   T2 pc=05, branch_taken=1, target=40 -> next pc=40, flush=1 for 1 cycle,
//      then pc=41.
//   T3 pc=10, stall=1 for 3 cycles; jump 80 in stall cycle 1, branch 20 in
//      stall cycle 2 -> pc stays 10; after stall drops pc=80, flush=1 once,
//      branch 20 is never taken.
//   T4 pc=FF, no events -> pc=00. Also jump_en=1 and branch_taken=1 at once
//      (jump 50, branch 60) -> pc=50.
//   T5 pc=30, jump_en+link_en, target 90 -> pc=90, link_addr=31. Later plain
//      jump -> link_addr stays 31.
//   T6 pc=22, halt_req -> halted=1, pc=22 for 5 cycles despite branch_taken.
//      resume -> pc=23, halted=0. Halt again, then rst mid-HALT -> pc=00,
//      halted=0.

Source files
------------

// File: rtl/pc_seq_if.sv
// Fetch-stage PC sequencer bundle: next-PC controls from the pipeline
// and the registered PC state back out.
interface pc_seq_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pc_inc;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            jump_en;
    logic [PC_W-1:0] jump_target;
    logic            link_en;
    logic            stall;
    logic            halt_req;
    logic            resume;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic [PC_W-1:0] link_addr;
    logic            halted;

    modport master (
        output pc_inc, branch_taken, branch_target,
        output jump_en, jump_target, link_en,
        output stall, halt_req, resume,
        input  pc, flush, link_addr, halted
    );

    modport slave (
        input  pc_inc, branch_taken, branch_target,
        input  jump_en, jump_target, link_en,
        input  stall, halt_req, resume,
        output pc, flush, link_addr, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// KGP_RISC fetch PC register and next-PC selector with one-deep
// redirect buffer for stalls, link capture and halt/resume.
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic   clk,
    input logic   rst,
    pc_seq_if.slave bus
);
    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] link_q;
    logic [PC_W-1:0] pend_target;
    logic            pend_valid;
    logic            flush_q;
    logic            halted_q;

    logic            redirect;
    logic            do_link;
    logic [PC_W-1:0] target;

    assign redirect = bus.jump_en | bus.branch_taken;
    assign do_link  = bus.jump_en & bus.link_en;
    assign target   = bus.jump_en ? bus.jump_target
                                  : bus.branch_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc_q        <= RESET_PC;
            link_q      <= '0;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.stall) begin
                        // Oldest redirect wins while stalled.
                        if (redirect && !pend_valid) begin
                            pend_target <= target;
                            pend_valid  <= 1'b1;
                            if (do_link) link_q <= bus.pc_inc;
                        end
                    end else if (pend_valid) begin
                        pc_q       <= pend_target;
                        pend_valid <= 1'b0;
                        flush_q    <= 1'b1;
                    end else if (bus.halt_req) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (redirect) begin
                        pc_q    <= target;
                        flush_q <= 1'b1;
                        if (do_link) link_q <= bus.pc_inc;
                    end else begin
                        pc_q <= bus.pc_inc;
                    end
                end
                HALT: begin
                    if (bus.resume) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                        pc_q     <= bus.pc_inc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flush     = flush_q;
    assign bus.link_addr = link_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, redirects, stall buffering,
// wrap, link capture and halt/resume.
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    pc_seq_if #(.PC_W(8)) bus ();

    pc_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behaves as the external incrementor.
    assign bus.pc_inc = bus.pc + 8'h01;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_in();
        bus.branch_taken  = 1'b0;
        bus.branch_target = 8'h00;
        bus.jump_en       = 1'b0;
        bus.jump_target   = 8'h00;
        bus.link_en       = 1'b0;
        bus.stall         = 1'b0;
        bus.halt_req      = 1'b0;
        bus.resume        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [7:0] v);
        clear_in();
        bus.jump_en     = 1'b1;
        bus.jump_target = v;
        tick();
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        tick();
        total++;
        if (bus.pc !== 8'h00 || bus.flush !== 1'b0 ||
            bus.halted !== 1'b0 || bus.link_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset pc=%h fl=%b h=%b lk=%h req 00/0/0/00",
                     bus.pc, bus.flush, bus.halted, bus.link_addr);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if (bus.pc !== 8'(i) || bus.flush !== 1'b0 ||
                bus.halted !== 1'b0) begin
                bad++;
                $display("FAIL run%0d pc=%h fl=%b h=%b req %h/0/0",
                         i, bus.pc, bus.flush, bus.halted, 8'(i));
            end
        end
    endtask

    task automatic test_branch();
        goto_pc(8'h05);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h40;
        tick();
        clear_in();
        total++;
        if (bus.pc !== 8'h40 || bus.flush !== 1'b1) begin
            bad++;
            $display("FAIL branch pc=%h fl=%b req 40/1",
                     bus.pc, bus.flush);
        end
        tick();
        total++;
        if (bus.pc !== 8'h41 || bus.flush !== 1'b0) begin
            bad++;
            $display("FAIL branch_next pc=%h fl=%b req 41/0",
                     bus.pc, bus.flush);
        end
    endtask

    task automatic test_stall_buffer();
        goto_pc(8'h10);
        bus.stall       = 1'b1;
        bus.jump_en     = 1'b1;
        bus.jump_target = 8'h80;
        tick();
        total++;
        if (bus.pc !== 8'h10 || bus.flush !== 1'b0) begin
            bad++;
            $display("FAIL stall1 pc=%h fl=%b req 10/0",
                     bus.pc, bus.flush);
        end
        bus.jump_en       = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h20;
        tick();
        total++;
        if (bus.pc !== 8'h10) begin
            bad++;
            $display("FAIL stall2 pc=%h req 10", bus.pc);
        end
        bus.branch_taken = 1'b0;
        tick();
        total++;
        if (bus.pc !== 8'h10 || bus.flush !== 1'b0) begin
            bad++;
            $display("FAIL stall3 pc=%h fl=%b req 10/0",
                     bus.pc, bus.flush);
        end
        bus.stall = 1'b0;
        tick();
        total++;
        if (bus.pc !== 8'h80 || bus.flush !== 1'b1) begin
            bad++;
            $display("FAIL unstall pc=%h fl=%b req 80/1",
                     bus.pc, bus.flush);
        end
        tick();
        total++;
        if (bus.pc !== 8'h81 || bus.flush !== 1'b0) begin
            bad++;
            $display("FAIL unstall_next pc=%h fl=%b req 81/0",
                     bus.pc, bus.flush);
        end
    endtask

    task automatic test_wrap_priority();
        goto_pc(8'hFF);
        tick();
        total++;
        if (bus.pc !== 8'h00) begin
            bad++;
            $display("FAIL wrap pc=%h req 00", bus.pc);
        end
        bus.jump_en       = 1'b1;
        bus.jump_target   = 8'h50;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h60;
        tick();
        clear_in();
        total++;
        if (bus.pc !== 8'h50 || bus.flush !== 1'b1) begin
            bad++;
            $display("FAIL jmp_prio pc=%h fl=%b req 50/1",
                     bus.pc, bus.flush);
        end
    endtask

    task automatic test_link();
        goto_pc(8'h30);
        bus.jump_en     = 1'b1;
        bus.link_en     = 1'b1;
        bus.jump_target = 8'h90;
        tick();
        clear_in();
        total++;
        if (bus.pc !== 8'h90 || bus.link_addr !== 8'h31) begin
            bad++;
            $display("FAIL jal pc=%h lk=%h req 90/31",
                     bus.pc, bus.link_addr);
        end
        bus.jump_en     = 1'b1;
        bus.jump_target = 8'h70;
        tick();
        clear_in();
        total++;
        if (bus.pc !== 8'h70 || bus.link_addr !== 8'h31) begin
            bad++;
            $display("FAIL plain_jmp pc=%h lk=%h req 70/31",
                     bus.pc, bus.link_addr);
        end
    endtask

    task automatic test_halt();
        goto_pc(8'h22);
        bus.halt_req = 1'b1;
        tick();
        clear_in();
        total++;
        if (bus.pc !== 8'h22 || bus.halted !== 1'b1) begin
            bad++;
            $display("FAIL halt pc=%h h=%b req 22/1",
                     bus.pc, bus.halted);
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 8'h40;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.pc !== 8'h22 || bus.halted !== 1'b1) begin
                bad++;
                $display("FAIL halt_hold%0d pc=%h h=%b req 22/1",
                         i, bus.pc, bus.halted);
            end
        end
        clear_in();
        bus.resume = 1'b1;
        tick();
        clear_in();
        total++;
        if (bus.pc !== 8'h23 || bus.halted !== 1'b0 ||
            bus.flush !== 1'b0) begin
            bad++;
            $display("FAIL resume pc=%h h=%b fl=%b req 23/0/0",
                     bus.pc, bus.halted, bus.flush);
        end
        bus.halt_req = 1'b1;
        tick();
        clear_in();
        total++;
        if (bus.halted !== 1'b1) begin
            bad++;
            $display("FAIL halt2 h=%b req 1", bus.halted);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.pc !== 8'h00 || bus.halted !== 1'b0) begin
            bad++;
            $display("FAIL rst_halt pc=%h h=%b req 00/0",
                     bus.pc, bus.halted);
        end
    endtask

    task automatic test_back_to_back();
        goto_pc(8'h60);
        bus.stall       = 1'b1;
        bus.jump_en     = 1'b1;
        bus.jump_target = 8'h44;
        tick();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus.pc !== 8'h01 || bus.flush !== 1'b0) begin
            bad++;
            $display("FAIL rst_pend pc=%h fl=%b req 01/0",
                     bus.pc, bus.flush);
        end
        bus.stall       = 1'b1;
        bus.jump_en     = 1'b1;
        bus.link_en     = 1'b1;
        bus.jump_target = 8'hA0;
        tick();
        clear_in();
        bus.halt_req = 1'b1;
        tick();
        clear_in();
        total++;
        if (bus.pc !== 8'hA0 || bus.halted !== 1'b0 ||
            bus.link_addr !== 8'h02) begin
            bad++;
            $display("FAIL pend_vs_halt pc=%h h=%b lk=%h req A0/0/02",
                     bus.pc, bus.halted, bus.link_addr);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_in();
        test_reset();
        test_branch();
        test_stall_buffer();
        test_wrap_priority();
        test_link();
        test_halt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
